// File: rtl/fpga_cfg_pkg.sv
// Shared types and sizing helpers for the FPGA row configuration loader.
// Pure declarations: no logic, no latency.
// Sizing functions are constant functions usable in parameter context.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_CSUM,
    ST_COMMIT,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  localparam logic [7:0] CFG_MAGIC_DEFAULT = 8'hA5;

  // Routing blocks: one per column, 12 select bits per wire.
  function automatic int brb_bits(input int width, input int wires);
    return width * wires * 12;
  endfunction

  // Switch blocks sit between columns: wires x wires crosspoints, 12 bits each.
  function automatic int bsb_bits(input int width, input int wires);
    return (width - 1) * wires * wires * 12;
  endfunction

  // Logic blocks: LUT truth table plus one sync bit each.
  function automatic int lb_bits(input int width, input int lut_k);
    return (width - 1) * ((1 << lut_k) + 1);
  endfunction

  function automatic int cfg_nwords(input int bits, input int data_w);
    return (bits + data_w - 1) / data_w;
  endfunction

  // Counter width for a word index, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpga_cfg_shadow_reg.sv
// Word-addressed shadow register with an atomic full-width copy into the active register.
// Latency: a write lands on the next edge; commit updates active on the next edge.
// No backpressure: writes and commits are accepted every cycle they are asserted.
module fpga_cfg_shadow_reg #(
  parameter int DATA_W   = 32,
  parameter int NWORDS   = 20,
  parameter int CFG_BITS = 632,
  parameter int IDX_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                commit,
  output logic [CFG_BITS-1:0] active
);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;

  // Per-slot write mux; pad bits beyond CFG_BITS in the last word are never stored.
  for (genvar w = 0; w < NWORDS; w++) begin : g_slot
    localparam int LO = w * DATA_W;
    localparam int HI = ((LO + DATA_W) > CFG_BITS) ? CFG_BITS : (LO + DATA_W);
    localparam int N  = HI - LO;
    assign shadow_d[HI-1:LO] = (wr_en && (wr_idx == IDX_W'(w))) ? wr_data[N-1:0]
                                                                 : shadow_q[HI-1:LO];
  end

  // Commit copies the whole shadow in one edge so the fabric never sees a mix.
  always_comb begin
    active_d = active_q;
    if (commit) begin
      active_d = shadow_q;
    end
  end

  // Shadow and active storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/fpga_row_cfg_loader.sv
// Loads a framed, XOR-checksummed bitstream into one FPGA row's select vectors (optional readback: FPGA_CFG_READBACK_EN).
// Latency: active selects and cfg_done update one edge after the checksum word is accepted.
// Backpressure: in_ready depends on state only (high while collecting header/payload/checksum).
module fpga_row_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int         FPGA_WIDTH = 5,
  parameter int         WIRE_WIDTH = 3,
  parameter int         LUT_K      = 2,
  parameter int         DATA_W     = 32,
  parameter logic [7:0] MAGIC      = CFG_MAGIC_DEFAULT
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           cfg_start,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [DATA_W-1:0]                              in_data,
  output logic [FPGA_WIDTH*WIRE_WIDTH*12-1:0]            brbselect,
  output logic [(FPGA_WIDTH-1)*WIRE_WIDTH*WIRE_WIDTH*12-1:0] bsbselect,
  output logic [(FPGA_WIDTH-1)*((2**LUT_K)+1)-1:0]       lbselect,
  output logic                                           cfg_busy,
  output logic                                           cfg_done,
  output logic                                           cfg_err
`ifdef FPGA_CFG_READBACK_EN
  ,
  input  logic                                           rb_req,
  output logic                                           rb_valid,
  output logic [DATA_W-1:0]                              rb_data
`endif
);

  localparam int BRB_W    = brb_bits(FPGA_WIDTH, WIRE_WIDTH);
  localparam int BSB_W    = bsb_bits(FPGA_WIDTH, WIRE_WIDTH);
  localparam int LB_W     = lb_bits(FPGA_WIDTH, LUT_K);
  localparam int CFG_BITS = BRB_W + BSB_W + LB_W;
  localparam int NWORDS   = cfg_nwords(CFG_BITS, DATA_W);
  localparam int IDX_W    = idx_width(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  cfg_state_e          state_q, state_d;
  logic [IDX_W-1:0]    word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic                cfg_busy_q, cfg_busy_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic                fire;
  logic                wr_en;
  logic                commit;
  logic [CFG_BITS-1:0] cfg_active;

  // Ready is a pure state decode so upstream can never form a combinational loop.
  assign in_ready = (state_q == ST_HDR) || (state_q == ST_PAY) || (state_q == ST_CSUM);

  // Next-state, counter and checksum logic; cfg_start overrides any word in the same cycle.
  always_comb begin
    fire       = in_valid && in_ready && !cfg_start;
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    wr_en      = 1'b0;
    commit     = (state_q == ST_COMMIT);
    if (cfg_start) begin
      state_d    = ST_HDR;
      word_cnt_d = '0;
      csum_d     = '0;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (fire) begin
            state_d = (in_data[DATA_W-1 -: 8] == MAGIC) ? ST_PAY : ST_ERR;
          end
        end
        ST_PAY: begin
          if (fire) begin
            wr_en      = 1'b1;
            csum_d     = csum_q ^ in_data;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == LAST_IDX) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (fire) begin
            state_d = (in_data == csum_q) ? ST_COMMIT : ST_ERR;
          end
        end
        ST_COMMIT: state_d = ST_DONE;
        default: ;
      endcase
    end
    cfg_busy_d = (state_d == ST_HDR) || (state_d == ST_PAY) ||
                 (state_d == ST_CSUM) || (state_d == ST_COMMIT);
    cfg_done_d = (state_d == ST_DONE);
    cfg_err_d  = (state_d == ST_ERR);
  end

  // Loader FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      csum_q     <= '0;
      cfg_busy_q <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      cfg_busy_q <= cfg_busy_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  fpga_cfg_shadow_reg #(
    .DATA_W   (DATA_W),
    .NWORDS   (NWORDS),
    .CFG_BITS (CFG_BITS),
    .IDX_W    (IDX_W)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (word_cnt_q),
    .wr_data (in_data),
    .commit  (commit),
    .active  (cfg_active)
  );

  assign brbselect = cfg_active[BRB_W-1:0];
  assign bsbselect = cfg_active[BRB_W +: BSB_W];
  assign lbselect  = cfg_active[BRB_W+BSB_W +: LB_W];
  assign cfg_busy  = cfg_busy_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;

`ifdef FPGA_CFG_READBACK_EN
  logic [NWORDS*DATA_W-1:0] rb_vec;
  logic [DATA_W-1:0]        rb_words [NWORDS];
  logic                     rb_valid_q, rb_valid_d;
  logic [IDX_W-1:0]         rb_idx_q, rb_idx_d;
  logic [DATA_W-1:0]        rb_data_q, rb_data_d;

  // Active config zero-extended to whole words, in the same order it was loaded.
  always_comb begin
    rb_vec                 = '0;
    rb_vec[CFG_BITS-1:0]   = cfg_active;
  end

  for (genvar w = 0; w < NWORDS; w++) begin : g_rb_word
    assign rb_words[w] = rb_vec[w*DATA_W +: DATA_W];
  end

  // Stream sequencer: starts only from DONE when idle, cfg_start cancels it.
  always_comb begin
    rb_valid_d = rb_valid_q;
    rb_idx_d   = rb_idx_q;
    rb_data_d  = rb_data_q;
    if (cfg_start) begin
      rb_valid_d = 1'b0;
      rb_idx_d   = '0;
      rb_data_d  = '0;
    end else if (rb_valid_q) begin
      if (rb_idx_q == LAST_IDX) begin
        rb_valid_d = 1'b0;
        rb_data_d  = '0;
      end else begin
        rb_idx_d  = rb_idx_q + 1'b1;
        rb_data_d = rb_words[rb_idx_d];
      end
    end else if (rb_req && (state_q == ST_DONE)) begin
      rb_valid_d = 1'b1;
      rb_idx_d   = '0;
      rb_data_d  = rb_words[0];
    end
  end

  // Readback output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_valid_q <= 1'b0;
      rb_idx_q   <= '0;
      rb_data_q  <= '0;
    end else begin
      rb_valid_q <= rb_valid_d;
      rb_idx_q   <= rb_idx_d;
      rb_data_q  <= rb_data_d;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;
`endif

endmodule

// File: tb/tb_fpga_row_cfg_loader.sv
// Bench for fpga_row_cfg_loader at default parameters (readback checked when FPGA_CFG_READBACK_EN is defined).
// A transaction-level model tracks the expected outputs; a compare process checks them every cycle.
// Directed loads pin the model with literal values, then randomized loads exercise gaps, aborts and errors.
module tb_fpga_row_cfg_loader;

  localparam int W    = 5;
  localparam int WW   = 3;
  localparam int K    = 2;
  localparam int DW   = 32;
  localparam int BRB  = W * WW * 12;
  localparam int BSB  = (W - 1) * WW * WW * 12;
  localparam int LB   = (W - 1) * ((1 << K) + 1);
  localparam int CFGB = BRB + BSB + LB;
  localparam int NW   = (CFGB + DW - 1) / DW;
  localparam int VW   = NW * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [BRB-1:0] brbselect;
  logic [BSB-1:0] bsbselect;
  logic [LB-1:0]  lbselect;
  logic          cfg_busy, cfg_done, cfg_err;
`ifdef FPGA_CFG_READBACK_EN
  logic          rb_req = 1'b0;
  logic          rb_valid;
  logic [DW-1:0] rb_data;
`endif

  fpga_row_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .brbselect (brbselect),
    .bsbselect (bsbselect),
    .lbselect  (lbselect),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
`ifdef FPGA_CFG_READBACK_EN
    ,
    .rb_req    (rb_req),
    .rb_valid  (rb_valid),
    .rb_data   (rb_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A load is: header word, NW payload words, checksum word. The model just collects
  // the words of the current load and decides at the checksum word.
  logic [VW-1:0] m_active = '0;
  bit            m_loading = 1'b0;
  bit            m_commit  = 1'b0;
  bit            m_done    = 1'b0;
  bit            m_err     = 1'b0;
  int            m_recv    = 0;
  logic [DW-1:0] m_words[$];
  logic [DW-1:0] m_rb[$];
  logic [VW-1:0] m_tmp;
  logic [DW-1:0] m_x;

  function automatic void m_begin();
    m_loading = 1'b1;
    m_recv    = 0;
    m_done    = 1'b0;
    m_err     = 1'b0;
    m_words.delete();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active  = '0;
      m_loading = 1'b0;
      m_commit  = 1'b0;
      m_done    = 1'b0;
      m_err     = 1'b0;
      m_recv    = 0;
      m_words.delete();
      m_rb.delete();
    end else begin
`ifdef FPGA_CFG_READBACK_EN
      if (cfg_start) m_rb.delete();
      else if (m_rb.size() > 0) void'(m_rb.pop_front());
      else if (rb_req && m_done) begin
        for (int i = 0; i < NW; i++) m_rb.push_back(m_active[i*DW +: DW]);
      end
`endif
      if (m_commit) begin
        m_tmp = '0;
        for (int i = 0; i < NW; i++) m_tmp[i*DW +: DW] = m_words[i];
        for (int b = CFGB; b < VW; b++) m_tmp[b] = 1'b0;
        m_active = m_tmp;
        m_commit = 1'b0;
        if (cfg_start) m_begin();
        else m_done = 1'b1;
      end else if (cfg_start) begin
        m_begin();
      end else if (m_loading && in_valid) begin
        if (m_recv == 0) begin
          if (in_data[DW-1:DW-8] == 8'hA5) m_recv = 1;
          else begin
            m_loading = 1'b0;
            m_err     = 1'b1;
          end
        end else if (m_recv <= NW) begin
          m_words.push_back(in_data);
          m_recv++;
        end else begin
          m_x = '0;
          foreach (m_words[i]) m_x ^= m_words[i];
          m_loading = 1'b0;
          if (in_data == m_x) m_commit = 1'b1;
          else m_err = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_loading);
    chk("cfg_busy", cfg_busy, m_loading || m_commit);
    chk("cfg_done", cfg_done, m_done);
    chk("cfg_err", cfg_err, m_err);
    chk("brbselect", brbselect, m_active[BRB-1:0]);
    chk("bsbselect", bsbselect, m_active[BRB +: BSB]);
    chk("lbselect", lbselect, m_active[BRB+BSB +: LB]);
`ifdef FPGA_CFG_READBACK_EN
    chk("rb_valid", rb_valid, m_rb.size() > 0);
    if (m_rb.size() > 0) chk("rb_data", rb_data, m_rb[0]);
`endif
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] stim [NW];

  function automatic logic [VW-1:0] pack_stim();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NW; i++) v[i*DW +: DW] = stim[i];
    for (int b = CFGB; b < VW; b++) v[b] = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      in_valid  = 1'b0;
      cfg_start = 1'b0;
    end
  endtask

  task automatic pulse_start();
    tick();
    cfg_start = 1'b1;
    in_valid  = 1'b0;
    tick();
    cfg_start = 1'b0;
  endtask

  // Present one word (after optional idle gap) and hold it until the edge that takes it.
  task automatic send_word(input logic [DW-1:0] w, input int gap);
    int budget;
    for (int g = 0; g < gap; g++) begin
      tick();
      in_valid = 1'b0;
      in_data  = $urandom;
    end
    tick();
    in_valid = 1'b1;
    in_data  = w;
    budget   = 50;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout in_ready=0 required=1");
    end
  endtask

  task automatic load(input logic [7:0] tag, input logic [DW-1:0] flip,
                      input int gmin, input int gmax, input bit start_in_commit);
    logic [DW-1:0] hdr;
    logic [DW-1:0] x;
    pulse_start();
    hdr = $urandom;
    hdr[DW-1:DW-8] = tag;
    send_word(hdr, $urandom_range(gmax, gmin));
    if (tag != 8'hA5) begin
      idle(2);
      return;
    end
    x = '0;
    for (int i = 0; i < NW; i++) begin
      send_word(stim[i], $urandom_range(gmax, gmin));
      x ^= stim[i];
    end
    send_word(x ^ flip, $urandom_range(gmax, gmin));
    if (start_in_commit) pulse_start();
    idle(3);
  endtask

  task automatic partial(input int n);
    pulse_start();
    send_word(32'hA500_0000, 0);
    for (int i = 0; i < n; i++) send_word($urandom, 0);
  endtask

  int            rb_cnt;
  logic [DW-1:0] rb_last;
  logic [VW-1:0] expv;
  int            mode, gmax;
  logic [DW-1:0] flip;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_brb", brbselect, 0);
    idle(2);

    // Directed load: words 1..20, checksum of 1..20 is 0x14.
    pulse_start();
    send_word(32'hA500_0000, 0);
    for (int i = 0; i < NW; i++) send_word(DW'(i + 1), 0);
    send_word(32'h0000_0014, 0);
    idle(3);
    chk("t1_done", cfg_done, 1);
    chk("t1_brb_lo", brbselect[31:0], 32'h1);
    chk("t1_lb", lbselect, 20'h1);
    chk("t1_model_lb", m_active[631:612], 20'h1);

`ifdef FPGA_CFG_READBACK_EN
    tick();
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    rb_cnt = 0;
    rb_last = '1;
    for (int c = 0; c < 30; c++) begin
      if (rb_valid) begin
        rb_cnt++;
        rb_last = rb_data;
      end
      tick();
    end
    chk("rb_count", rb_cnt, NW);
    chk("rb_last_word", rb_last, 32'h14);
`endif

    // Same stream, corrupted checksum: rejected, config retained.
    pulse_start();
    send_word(32'hA500_0000, 0);
    for (int i = 0; i < NW; i++) send_word(DW'(i + 1), 0);
    send_word(32'h0000_0015, 0);
    idle(3);
    chk("t2_err", cfg_err, 1);
    chk("t2_done", cfg_done, 0);
    chk("t2_brb_lo", brbselect[31:0], 32'h1);
    chk("t2_lb", lbselect, 20'h1);

    // Bad header.
    pulse_start();
    send_word(32'h5A00_0000, 0);
    idle(2);
    chk("t3_ready", in_ready, 0);
    chk("t3_err", cfg_err, 1);
    chk("t3_busy", cfg_busy, 0);

    // Abort after 7 payload words, then a full stream.
    for (int i = 0; i < NW; i++) stim[i] = $urandom;
    partial(7);
    load(8'hA5, '0, 0, 0, 1'b0);
    expv = pack_stim();
    chk("t4_done", cfg_done, 1);
    chk("t4_bsb", bsbselect, expv[BRB +: BSB]);

    // Same data with valid toggling every other cycle.
    load(8'hA5, '0, 1, 1, 1'b0);
    chk("t5_done", cfg_done, 1);
    chk("t5_brb", brbselect, expv[BRB-1:0]);
    chk("t5_lb", lbselect, expv[BRB+BSB +: LB]);

    // cfg_start during COMMIT: commit lands, loader back in HDR.
    for (int i = 0; i < NW; i++) stim[i] = $urandom;
    load(8'hA5, '0, 0, 0, 1'b1);
    expv = pack_stim();
    chk("t6_done", cfg_done, 0);
    chk("t6_busy", cfg_busy, 1);
    chk("t6_brb", brbselect, expv[BRB-1:0]);

    // Reset mid-load clears the active config.
    partial(5);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("t7_brb", brbselect, 0);
    chk("t7_busy", cfg_busy, 0);
    rst_n = 1'b1;
    idle(2);

    // Randomized loads.
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 9);
      gmax = $urandom_range(0, 3);
      for (int i = 0; i < NW; i++) stim[i] = $urandom;
      flip = DW'(1) << $urandom_range(0, DW - 1);
      case (mode)
        0: load(8'h3C, '0, 0, gmax, 1'b0);
        1: load(8'hA5, flip, 0, gmax, 1'b0);
        2: begin
          partial($urandom_range(0, NW - 1));
          load(8'hA5, '0, 0, gmax, 1'b0);
        end
        3: load(8'hA5, '0, 0, gmax, 1'b1);
        default: load(8'hA5, '0, 0, gmax, 1'b0);
      endcase
`ifdef FPGA_CFG_READBACK_EN
      if ($urandom_range(0, 1) == 1) begin
        tick();
        rb_req = 1'b1;
        tick();
        rb_req = 1'b0;
        repeat (5) tick();
        rb_req = 1'b1;
        tick();
        rb_req = 1'b0;
        idle($urandom_range(2, NW + 4));
      end
`endif
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not reach the end");
    $fatal(1);
  end

endmodule
